// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_if
//  Description : Instruction-fetch bus between the fetch front end (master)
//                and the instruction memory / bus fabric (slave).
//                Request/grant address phase followed by in-order read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if;

    logic        fetch_req;     // request valid
    logic [31:0] fetch_addr;    // word address of the request
    logic        fetch_gnt;     // request accepted this cycle
    logic        fetch_rvalid;  // read data valid, responses in request order
    logic [31:0] fetch_rdata;   // read data

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_gnt,
        input  fetch_rvalid,
        input  fetch_rdata
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_gnt,
        output fetch_rvalid,
        output fetch_rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch front end. Owns the program counter,
//                issues word fetches under a credit limit, tags every request
//                with its pc, buffers returned words in a prefetch FIFO and
//                presents the head to the IF/ID register. Branch redirects
//                flush the FIFO and drop responses of requests still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        ex_branch_flag_i,
    input  wire logic [31:0] ex_branch_addr_i,
    input  wire logic [4:0]  stalled_i,
    if_fetch_if.master       bus,
    output logic      [31:0] pc_o,
    output logic      [31:0] inst_o,
    output logic             stall_req_o
);

    // Pointers index a power-of-two ring, counters must hold 0..FIFO_DEPTH.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;

    logic [31:0]      fetch_pc;

    // Prefetch FIFO of {pc, inst}
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_rd;
    logic [PTR_W-1:0] fifo_wr;
    logic [CNT_W-1:0] fifo_count;

    // pc tags of granted requests whose data will be kept (stale ones are
    // not tagged, they are only counted in discard)
    logic [31:0]      tag_pc [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_rd;
    logic [PTR_W-1:0] tag_wr;
    logic [CNT_W-1:0] tag_count;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] discard_next;

    logic             redirect;
    logic             gnt_fire;
    logic             rvalid;
    logic             rsp_accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             tag_push;
    logic             tag_pop;
    logic [CNT_W:0]   credit_used;

    // Control bits this block does not act on
    logic             unused_bits;
    assign unused_bits = ^{stalled_i[4:2], stalled_i[0], ex_branch_addr_i[1:0]};

    assign redirect   = ex_branch_flag_i;
    assign rvalid     = bus.fetch_rvalid;
    assign gnt_fire   = bus.fetch_req && bus.fetch_gnt;
    assign fifo_empty = (fifo_count == '0);

    // A response is kept only when nothing stale is ahead of it and no
    // redirect is flushing the FIFO in the same cycle.
    assign rsp_accept = rvalid && (discard == '0) && !redirect;
    assign fifo_push  = rsp_accept;
    assign tag_pop    = rsp_accept;
    assign tag_push   = gnt_fire && !redirect;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: BOOT lasts one cycle, DRAIN while stale responses remain
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = (discard_next != '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (discard_next != '0) state_next = ST_DRAIN;
            ST_DRAIN: if (discard_next == '0) state_next = ST_RUN;
            default:  state_next = ST_BOOT;
        endcase
    end

    // Outputs: head pop and credit-limited bus request. The entry popped this
    // cycle frees its slot, so it does not consume a credit; otherwise a
    // two-entry FIFO could not sustain one instruction per cycle. Every
    // future push still has a reserved slot, so the FIFO cannot overflow.
    always_comb begin
        fifo_pop       = !fifo_empty && !stalled_i[1] && !redirect;
        credit_used    = {1'b0, fifo_count} + {1'b0, outstanding}
                       - {{CNT_W{1'b0}}, fifo_pop};
        bus.fetch_req  = (state != ST_BOOT) && (credit_used < DEPTH_C);
        bus.fetch_addr = fetch_pc;
    end

    // In-flight and stale-response counters for the coming cycle
    always_comb begin
        outstanding_next = outstanding;
        if (gnt_fire && !rvalid) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!gnt_fire && rvalid && (outstanding != '0)) begin
            outstanding_next = outstanding - CNT_W'(1);
        end

        discard_next = discard;
        if (redirect) begin
            // Everything still in flight after this cycle is stale,
            // including a request granted right now.
            discard_next = outstanding_next;
        end else if (rvalid && (discard != '0)) begin
            discard_next = discard - CNT_W'(1);
        end
    end

    // Counters and program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            if (redirect) begin
                fetch_pc <= {ex_branch_addr_i[31:2], 2'b00};
            end else if (gnt_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
        end else if (redirect) begin
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) fifo_wr <= fifo_wr + PTR_W'(1);
            if (fifo_pop)  fifo_rd <= fifo_rd + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Tag-queue pointers and occupancy; a redirect clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd    <= '0;
            tag_wr    <= '0;
            tag_count <= '0;
        end else if (redirect) begin
            tag_rd    <= '0;
            tag_wr    <= '0;
            tag_count <= '0;
        end else begin
            if (tag_push) tag_wr <= tag_wr + PTR_W'(1);
            if (tag_pop)  tag_rd <= tag_rd + PTR_W'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    // Storage arrays; occupancy counters decide which entries are valid
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
            fifo_inst[fifo_wr] <= bus.fetch_rdata;
        end
        if (tag_push) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
    end

    // Head presentation: instruction when buffered, bubble otherwise
    always_comb begin
        pc_o        = fetch_pc;
        inst_o      = 32'h0000_0000;
        stall_req_o = 1'b1;
        if (!fifo_empty) begin
            pc_o        = fifo_pc[fifo_rd];
            inst_o      = fifo_inst[fifo_rd];
            stall_req_o = 1'b0;
        end else if (tag_count != '0) begin
            pc_o = tag_pc[tag_rd];
        end
    end

endmodule
`default_nettype wire
